// File: rtl/game_pkg.sv
// game_pkg: shared direction codes, display bounds and life-cycle states
// for the playfield sprite controllers (enemy, player, bomb).
package game_pkg;

  // One-hot movement directions
  localparam logic [3:0] DIR_L    = 4'b1000;
  localparam logic [3:0] DIR_R    = 4'b0100;
  localparam logic [3:0] DIR_U    = 4'b0010;
  localparam logic [3:0] DIR_D    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  // Visible display area in VGA pixel coordinates
  localparam int unsigned DISP_MIN_X = 32'd143;
  localparam int unsigned DISP_MAX_X = 32'd784;
  localparam int unsigned DISP_MIN_Y = 32'd34;
  localparam int unsigned DISP_MAX_Y = 32'd516;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DYING = 2'd2,
    DEAD  = 2'd3
  } state_t;

  // Clockwise patrol rotation L -> U -> R -> D -> L
  function automatic logic [3:0] rotate_cw(input logic [3:0] d);
    logic [3:0] r;
    case (d)
      DIR_L:   r = DIR_U;
      DIR_U:   r = DIR_R;
      DIR_R:   r = DIR_D;
      DIR_D:   r = DIR_L;
      default: r = DIR_L;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: counts 0..DIV-1 while enabled and pulses tick on the last
// count, wrapping on that same cycle. clr forces the count back to zero.
module step_timer
  import game_pkg::*;
#(
  parameter int unsigned DIV = 32'd4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] count_r;

  // Step counter: clear has priority, otherwise count and wrap while enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(32'd1);
      end
    end
  end

  assign tick = en && (count_r == LAST);

endmodule

// File: rtl/enemy_walker.sv
// enemy_walker: one enemy sprite that patrols clockwise or chases the
// player, honours per-direction block flags, latches player overlap and
// runs a kill / flash / dead / respawn life cycle for the pixel mux.
module enemy_walker
  import game_pkg::*;
#(
  parameter int unsigned MODE        = 32'd0,
  parameter int unsigned STEP_DIV    = 32'd1400000,
  parameter int unsigned SPR_W       = 32'd16,
  parameter int unsigned SPR_H       = 32'd16,
  parameter int unsigned PL_W        = 32'd16,
  parameter int unsigned PL_H        = 32'd16,
  parameter int unsigned MIN_X       = DISP_MIN_X,
  parameter int unsigned MAX_X       = DISP_MAX_X,
  parameter int unsigned MIN_Y       = DISP_MIN_Y,
  parameter int unsigned MAX_Y       = DISP_MAX_Y,
  parameter int unsigned INIT_X      = 32'd143,
  parameter int unsigned INIT_Y      = 32'd34,
  parameter int unsigned FLASH_STEPS = 32'd32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [9:0]               spawn_x,
  input  logic [9:0]               spawn_y,
  input  logic [3:0]               blocked,
  input  logic                     kill,
  input  logic                     hit_clr,
  input  logic [9:0]               b_x,
  input  logic [9:0]               b_y,
  input  logic [9:0]               v_x,
  input  logic [9:0]               v_y,
  output logic [9:0]               enemy_x,
  output logic [9:0]               enemy_y,
  output logic [3:0]               dir,
  output logic                     alive,
  output logic                     player_hit,
  output logic                     enemy_on,
  output logic [$clog2(SPR_H)-1:0] spr_row,
  output logic [$clog2(SPR_W)-1:0] spr_col
);

  localparam int unsigned     ROW_W   = $clog2(SPR_H);
  localparam int unsigned     COL_W   = $clog2(SPR_W);
  localparam int unsigned     FL_W    = $clog2(FLASH_STEPS) + 32'd2;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_STEPS - 32'd1);
  localparam logic [9:0]      WALL_L  = 10'(MIN_X);
  localparam logic [9:0]      WALL_R  = 10'(MAX_X - SPR_W);
  localparam logic [9:0]      WALL_U  = 10'(MIN_Y);
  localparam logic [9:0]      WALL_D  = 10'(MAX_Y - SPR_H);
  localparam logic [10:0]     SPR_W11 = 11'(SPR_W);
  localparam logic [10:0]     SPR_H11 = 11'(SPR_H);
  localparam logic [10:0]     PL_W11  = 11'(PL_W);
  localparam logic [10:0]     PL_H11  = 11'(PL_H);

  state_t            state_r;
  logic [9:0]        ex_r, ey_r;
  logic [3:0]        dir_r;
  logic              alive_r, hit_r;
  logic [FL_W-1:0]   flash_r;
  logic              tick_s, timer_en_s, timer_clr_s;
  logic [3:0]        open_s;
  logic signed [10:0] dx_s, dy_s;
  logic [10:0]       adx_s, ady_s;
  logic [3:0]        xdir_s, ydir_s, pri_dir_s, sec_dir_s, chase_dir_s;
  logic [3:0]        move_dir_s, next_dir_s;
  logic [9:0]        next_x_s, next_y_s;
  logic              overlap_s, in_box_s;

  // Open-flag lookup for a one-hot direction; idle is never open
  function automatic logic dir_open(input logic [3:0] d, input logic [3:0] op);
    logic r;
    case (d)
      DIR_L:   r = op[0];
      DIR_R:   r = op[1];
      DIR_U:   r = op[2];
      DIR_D:   r = op[3];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // The counter only runs while moving or dying and restarts on a kill
  assign timer_en_s  = (state_r == MOVE) || (state_r == DYING);
  assign timer_clr_s = !timer_en_s || ((state_r == MOVE) && kill);

  step_timer #(.DIV(STEP_DIV)) u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (timer_en_s),
    .clr     (timer_clr_s),
    .tick    (tick_s)
  );

  // A direction is open when unblocked and the sprite is not at that wall
  always_comb begin
    open_s    = 4'b0000;
    open_s[0] = !blocked[0] && (ex_r > WALL_L);
    open_s[1] = !blocked[1] && (ex_r < WALL_R);
    open_s[2] = !blocked[2] && (ey_r > WALL_U);
    open_s[3] = !blocked[3] && (ey_r < WALL_D);
  end

  // Chase steering: the larger delta is the primary axis, ties go to X
  always_comb begin
    dx_s  = $signed({1'b0, b_x}) - $signed({1'b0, ex_r});
    dy_s  = $signed({1'b0, b_y}) - $signed({1'b0, ey_r});
    adx_s = dx_s[10] ? $unsigned(-dx_s) : $unsigned(dx_s);
    ady_s = dy_s[10] ? $unsigned(-dy_s) : $unsigned(dy_s);
    if (dx_s == 11'sd0) begin
      xdir_s = DIR_NONE;
    end else begin
      xdir_s = dx_s[10] ? DIR_L : DIR_R;
    end
    if (dy_s == 11'sd0) begin
      ydir_s = DIR_NONE;
    end else begin
      ydir_s = dy_s[10] ? DIR_U : DIR_D;
    end
    if (adx_s >= ady_s) begin
      pri_dir_s = xdir_s;
      sec_dir_s = ydir_s;
    end else begin
      pri_dir_s = ydir_s;
      sec_dir_s = xdir_s;
    end
    if (dir_open(pri_dir_s, open_s)) begin
      chase_dir_s = pri_dir_s;
    end else if (dir_open(sec_dir_s, open_s)) begin
      chase_dir_s = sec_dir_s;
    end else begin
      chase_dir_s = DIR_NONE;
    end
  end

  // Resolve this tick's heading and the position it leads to
  always_comb begin
    if (MODE == 32'd0) begin
      if (dir_open(dir_r, open_s)) begin
        move_dir_s = dir_r;
        next_dir_s = dir_r;
      end else if (open_s != 4'b0000) begin
        move_dir_s = DIR_NONE;
        next_dir_s = rotate_cw(dir_r);
      end else begin
        move_dir_s = DIR_NONE;
        next_dir_s = dir_r;
      end
    end else begin
      move_dir_s = chase_dir_s;
      next_dir_s = chase_dir_s;
    end
    next_x_s = ex_r;
    next_y_s = ey_r;
    case (move_dir_s)
      DIR_L:   next_x_s = ex_r - 10'd1;
      DIR_R:   next_x_s = ex_r + 10'd1;
      DIR_U:   next_y_s = ey_r - 10'd1;
      DIR_D:   next_y_s = ey_r + 10'd1;
      default: begin
        next_x_s = ex_r;
        next_y_s = ey_r;
      end
    endcase
  end

  // Strict AABB overlap and pixel in-box tests, 11-bit sums so nothing wraps
  always_comb begin
    overlap_s = ({1'b0, b_x} < ({1'b0, ex_r} + SPR_W11)) &&
                ({1'b0, ex_r} < ({1'b0, b_x} + PL_W11)) &&
                ({1'b0, b_y} < ({1'b0, ey_r} + SPR_H11)) &&
                ({1'b0, ey_r} < ({1'b0, b_y} + PL_H11));
    in_box_s  = ({1'b0, v_x} >= {1'b0, ex_r}) &&
                ({1'b0, v_x} < ({1'b0, ex_r} + SPR_W11)) &&
                ({1'b0, v_y} >= {1'b0, ey_r}) &&
                ({1'b0, v_y} < ({1'b0, ey_r} + SPR_H11));
  end

  // Visibility by state; while dying the sprite blanks on flash-count bit 1
  always_comb begin
    case (state_r)
      MOVE:    enemy_on = in_box_s;
      DYING:   enemy_on = in_box_s && !flash_r[1];
      default: enemy_on = 1'b0;
    endcase
  end

  // Life-cycle FSM with registered position, heading and alive flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ex_r    <= 10'(INIT_X);
      ey_r    <= 10'(INIT_Y);
      dir_r   <= DIR_NONE;
      alive_r <= 1'b0;
      flash_r <= '0;
    end else begin
      case (state_r)
        IDLE, DEAD: begin
          if (start) begin
            state_r <= MOVE;
            alive_r <= 1'b1;
            ex_r    <= spawn_x;
            ey_r    <= spawn_y;
            dir_r   <= (MODE == 32'd0) ? DIR_L : DIR_NONE;
          end
        end
        MOVE: begin
          if (kill) begin
            state_r <= DYING;
            alive_r <= 1'b0;
            flash_r <= '0;
          end else if (tick_s) begin
            ex_r  <= next_x_s;
            ey_r  <= next_y_s;
            dir_r <= next_dir_s;
          end
        end
        DYING: begin
          if (tick_s) begin
            if (flash_r == FL_LAST) begin
              state_r <= DEAD;
            end else begin
              flash_r <= flash_r + FL_W'(32'd1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          alive_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky player-hit flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_r <= 1'b0;
    end else if ((state_r == MOVE) && overlap_s) begin
      hit_r <= 1'b1;
    end else if (hit_clr) begin
      hit_r <= 1'b0;
    end
  end

  assign enemy_x    = ex_r;
  assign enemy_y    = ey_r;
  assign dir        = dir_r;
  assign alive      = alive_r;
  assign player_hit = hit_r;
  assign spr_col    = COL_W'(v_x - ex_r);
  assign spr_row    = ROW_W'(v_y - ey_r);

endmodule

// File: tb/tb_enemy_walker.sv
// tb_enemy_walker: directed scenarios plus randomized traffic on a patrol
// instance (step 4) and a chase instance (step 2), both checked every cycle
// against a behavioural model of the enemy rules.
module tb_enemy_walker;

  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] R = 4'b0100;
  localparam logic [3:0] U = 4'b0010;
  localparam logic [3:0] D = 4'b0001;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0]       start, kill, hit_clr;
  logic [1:0][9:0]  spawn_x, spawn_y, b_x, b_y, v_x, v_y;
  logic [1:0][3:0]  blocked;
  logic [1:0][9:0]  enemy_x, enemy_y;
  logic [1:0][3:0]  dir;
  logic [1:0]       alive, player_hit, enemy_on;
  logic [1:0][3:0]  spr_row, spr_col;

  int ntest = 0;
  int nfail = 0;

  // st: 0 idle, 1 moving, 2 dying, 3 dead
  typedef struct {
    int st; int x; int y; logic [3:0] dir; int cnt; int fl; bit hit;
  } mdl_t;
  mdl_t m [2];
  mdl_t rst_m;

  always #5 clk = ~clk;

  enemy_walker #(.MODE(0), .STEP_DIV(4), .FLASH_STEPS(FL)) u_patrol (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .spawn_x(spawn_x[0]), .spawn_y(spawn_y[0]),
    .blocked(blocked[0]), .kill(kill[0]), .hit_clr(hit_clr[0]), .b_x(b_x[0]), .b_y(b_y[0]),
    .v_x(v_x[0]), .v_y(v_y[0]), .enemy_x(enemy_x[0]), .enemy_y(enemy_y[0]), .dir(dir[0]),
    .alive(alive[0]), .player_hit(player_hit[0]), .enemy_on(enemy_on[0]),
    .spr_row(spr_row[0]), .spr_col(spr_col[0]));

  enemy_walker #(.MODE(1), .STEP_DIV(2), .FLASH_STEPS(FL)) u_chase (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .spawn_x(spawn_x[1]), .spawn_y(spawn_y[1]),
    .blocked(blocked[1]), .kill(kill[1]), .hit_clr(hit_clr[1]), .b_x(b_x[1]), .b_y(b_y[1]),
    .v_x(v_x[1]), .v_y(v_y[1]), .enemy_x(enemy_x[1]), .enemy_y(enemy_y[1]), .dir(dir[1]),
    .alive(alive[1]), .player_hit(player_hit[1]), .enemy_on(enemy_on[1]),
    .spr_row(spr_row[1]), .spr_col(spr_col[1]));

  function automatic int div_of(int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic bit is_open(int x, int y, logic [3:0] blk, logic [3:0] d);
    if (d == L) return !blk[0] && x > 143;
    if (d == R) return !blk[1] && x < 784 - 16;
    if (d == U) return !blk[2] && y > 34;
    if (d == D) return !blk[3] && y < 516 - 16;
    return 1'b0;
  endfunction

  function automatic bit ovl(int ex, int ey, int bx, int by);
    return bx < ex + 16 && ex < bx + 16 && by < ey + 16 && ey < by + 16;
  endfunction

  function automatic mdl_t shift(mdl_t c, logic [3:0] d);
    mdl_t n = c;
    if (d == L) n.x = c.x - 1;
    if (d == R) n.x = c.x + 1;
    if (d == U) n.y = c.y - 1;
    if (d == D) n.y = c.y + 1;
    return n;
  endfunction

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  // One clock of the enemy rules for instance k under its current inputs
  function automatic mdl_t mstep(mdl_t c, int k);
    mdl_t n = c;
    bit tick, any;
    int dx, dy;
    logic [3:0] pd, sd, xd, yd;
    logic [3:0] ring [4];
    ring = '{L, U, R, D};
    tick = (c.st == 1 || c.st == 2) && (c.cnt == div_of(k) - 1);
    if (c.st == 1 || c.st == 2) n.cnt = tick ? 0 : c.cnt + 1;
    if (c.st == 1 && ovl(c.x, c.y, int'(b_x[k]), int'(b_y[k]))) n.hit = 1'b1;
    else if (hit_clr[k]) n.hit = 1'b0;
    if (c.st == 0 || c.st == 3) begin
      if (start[k]) begin
        n.st = 1; n.x = int'(spawn_x[k]); n.y = int'(spawn_y[k]);
        n.dir = (k == 0) ? L : 4'b0000; n.cnt = 0;
      end
    end else if (c.st == 1) begin
      if (kill[k]) begin
        n.st = 2; n.cnt = 0; n.fl = 0;
      end else if (tick) begin
        if (k == 0) begin
          any = 1'b0;
          for (int i = 0; i < 4; i++) any |= is_open(c.x, c.y, blocked[k], ring[i]);
          if (is_open(c.x, c.y, blocked[k], c.dir)) n = shift(n, c.dir);
          else if (any)
            for (int i = 0; i < 4; i++) if (ring[i] == c.dir) n.dir = ring[(i + 1) % 4];
        end else begin
          dx = int'(b_x[k]) - c.x;
          dy = int'(b_y[k]) - c.y;
          xd = (dx > 0) ? R : (dx < 0) ? L : 4'b0000;
          yd = (dy > 0) ? D : (dy < 0) ? U : 4'b0000;
          if (iabs(dx) >= iabs(dy)) begin pd = xd; sd = yd; end
          else begin pd = yd; sd = xd; end
          if (is_open(c.x, c.y, blocked[k], pd)) n.dir = pd;
          else if (is_open(c.x, c.y, blocked[k], sd)) n.dir = sd;
          else n.dir = 4'b0000;
          n = shift(n, n.dir);
        end
      end
    end else if (c.st == 2 && tick) begin
      if (c.fl == FL - 1) n.st = 3;
      else n.fl = c.fl + 1;
    end
    return n;
  endfunction

  function automatic bit exp_on(mdl_t c, int k);
    bit inb;
    inb = int'(v_x[k]) >= c.x && int'(v_x[k]) < c.x + 16 &&
          int'(v_y[k]) >= c.y && int'(v_y[k]) < c.y + 16;
    if (c.st == 1) return inb;
    if (c.st == 2) return inb && (((c.fl >> 1) & 1) == 0);
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("x%0d", k), 32'(enemy_x[k]), m[k].x);
      chk($sformatf("y%0d", k), 32'(enemy_y[k]), m[k].y);
      chk($sformatf("dir%0d", k), 32'(dir[k]), 32'(m[k].dir));
      chk($sformatf("alive%0d", k), 32'(alive[k]), (m[k].st == 1) ? 1 : 0);
      chk($sformatf("hit%0d", k), 32'(player_hit[k]), 32'(m[k].hit));
      chk($sformatf("on%0d", k), 32'(enemy_on[k]), 32'(exp_on(m[k], k)));
      chk($sformatf("col%0d", k), 32'(spr_col[k]), (int'(v_x[k]) - m[k].x) & 15);
      chk($sformatf("row%0d", k), 32'(spr_row[k]), (int'(v_y[k]) - m[k].y) & 15);
    end
  endtask

  task automatic cyc();
    mdl_t n0, n1;
    n0 = mstep(m[0], 0);
    n1 = mstep(m[1], 1);
    @(posedge clk);
    m[0] = n0;
    m[1] = n1;
    #1;
    cmp_all();
  endtask

  task automatic clear_inputs();
    start = '0; kill = '0; hit_clr = '0; blocked = '0;
    spawn_x = '0; spawn_y = '0; b_x = '0; b_y = '0; v_x = '0; v_y = '0;
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    clear_inputs();
    m[0] = rst_m;
    m[1] = rst_m;
    #1;
    cmp_all();
    reset_n = 1'b1;
  endtask

  initial begin
    int t;
    rst_m = '{st: 0, x: 143, y: 34, dir: 4'b0000, cnt: 0, fl: 0, hit: 1'b0};
    m[0] = rst_m;
    m[1] = rst_m;
    clear_inputs();
    #12;
    cmp_all();
    reset_n = 1'b1;

    // Patrol from the left wall: turn up, climb to the top, turn right
    spawn_x[0] = 10'd143; spawn_y[0] = 10'd100; v_x[0] = 10'd150; v_y[0] = 10'd105;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    chk("patrol_start_dir", 32'(dir[0]), 32'(L));
    repeat (4) cyc();
    chk("patrol_turn_u", 32'(dir[0]), 32'(U));
    chk("patrol_x_hold", 32'(enemy_x[0]), 143);
    chk("patrol_y_hold", 32'(enemy_y[0]), 100);
    repeat (4 * 66) cyc();
    chk("patrol_top", 32'(enemy_y[0]), 34);
    repeat (4) cyc();
    chk("patrol_turn_r", 32'(dir[0]), 32'(R));
    repeat (4) cyc();
    chk("patrol_step_r", 32'(enemy_x[0]), 144);

    // Blocked left: turn up on the first tick, climb on the second
    do_reset();
    spawn_x[0] = 10'd300; spawn_y[0] = 10'd200; blocked[0] = 4'b0001;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (4) cyc();
    chk("blk_turn_u", 32'(dir[0]), 32'(U));
    chk("blk_y_first", 32'(enemy_y[0]), 200);
    repeat (4) cyc();
    chk("blk_y_second", 32'(enemy_y[0]), 199);
    chk("blk_x", 32'(enemy_x[0]), 300);

    // Chase with right blocked: fall back to down until dy reaches zero
    do_reset();
    spawn_x[1] = 10'd200; spawn_y[1] = 10'd200; b_x[1] = 10'd260; b_y[1] = 10'd220;
    blocked[1] = 4'b0010;
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    chk("chase_start_dir", 32'(dir[1]), 0);
    repeat (2 * 20) cyc();
    chk("chase_y", 32'(enemy_y[1]), 220);
    chk("chase_x", 32'(enemy_x[1]), 200);
    chk("chase_dir_d", 32'(dir[1]), 32'(D));
    repeat (2) cyc();
    chk("chase_dir_idle", 32'(dir[1]), 0);
    chk("chase_y_hold", 32'(enemy_y[1]), 220);

    // Collision boundary, then a clear that loses to a simultaneous set
    do_reset();
    spawn_x[1] = 10'd200; spawn_y[1] = 10'd200; blocked[1] = 4'b1111;
    b_x[1] = 10'd216; b_y[1] = 10'd200;
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    repeat (3) cyc();
    chk("hit_edge_none", 32'(player_hit[1]), 0);
    b_x[1] = 10'd215;
    cyc();
    chk("hit_overlap", 32'(player_hit[1]), 1);
    hit_clr[1] = 1'b1;
    cyc();
    chk("hit_set_wins", 32'(player_hit[1]), 1);
    b_x[1] = 10'd300;
    cyc();
    chk("hit_cleared", 32'(player_hit[1]), 0);
    hit_clr[1] = 1'b0;

    // Kill: flash for four steps, ignore start while dying, then respawn
    v_x[1] = 10'd205; v_y[1] = 10'd205;
    kill[1] = 1'b1;
    cyc();
    kill[1] = 1'b0;
    chk("kill_alive", 32'(alive[1]), 0);
    chk("flash_on0", 32'(enemy_on[1]), 1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin
        start[1] = 1'b1; spawn_x[1] = 10'd400; spawn_y[1] = 10'd300;
      end
      cyc();
      start[1] = 1'b0;
      chk($sformatf("flash_on%0d", i), 32'(enemy_on[1]), (i < 4) ? 1 : 0);
      chk($sformatf("dying_x%0d", i), 32'(enemy_x[1]), 200);
    end
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    chk("respawn_alive", 32'(alive[1]), 1);
    chk("respawn_x", 32'(enemy_x[1]), 400);
    chk("respawn_y", 32'(enemy_y[1]), 300);

    // Asynchronous reset between edges while both enemies move
    spawn_x[0] = 10'd500; spawn_y[0] = 10'd250; start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (5) cyc();
    #3;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_x%0d", k), 32'(enemy_x[k]), 143);
      chk($sformatf("arst_y%0d", k), 32'(enemy_y[k]), 34);
      chk($sformatf("arst_dir%0d", k), 32'(dir[k]), 0);
      chk($sformatf("arst_alive%0d", k), 32'(alive[k]), 0);
      chk($sformatf("arst_hit%0d", k), 32'(player_hit[k]), 0);
      chk($sformatf("arst_on%0d", k), 32'(enemy_on[k]), 0);
    end
    clear_inputs();
    m[0] = rst_m;
    m[1] = rst_m;
    @(posedge clk);
    #1;
    cmp_all();
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (m[k].st == 0 || m[k].st == 3) start[k] = ($urandom_range(0, 3) == 0);
        else start[k] = ($urandom_range(0, 29) == 0);
        spawn_x[k] = 10'($urandom_range(143, 768));
        spawn_y[k] = 10'($urandom_range(34, 500));
        blocked[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        kill[k]    = ($urandom_range(0, 49) == 0);
        hit_clr[k] = ($urandom_range(0, 5) == 0);
        t = m[k].x + int'($urandom_range(0, 48)) - 24;
        b_x[k] = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        t = m[k].y + int'($urandom_range(0, 48)) - 24;
        b_y[k] = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        t = m[k].x + int'($urandom_range(0, 24)) - 4;
        v_x[k] = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        t = m[k].y + int'($urandom_range(0, 24)) - 4;
        v_y[k] = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/enemy_walker.md
# enemy_walker

Parametrised enemy sprite controller and successor to the fixed-perimeter enemy. It moves one sprite through the playfield at a programmable step rate, in either a patrol mode or a player-chase mode, and honours per-direction block flags. It detects overlap with the player, handles a kill/flash/dead/respawn life cycle, and drives the per-pixel sprite hit and ROM coordinates to the top-level pixel mux.

## Interface
- `MODE`, 0: 0 = clockwise patrol, 1 = chase player.
- `STEP_DIV`, 1400000: clocks per movement step (≥2).
- `SPR_W` / `SPR_H`, 16 / 16: enemy sprite size (pixels).
- `PL_W` / `PL_H`, 16 / 16: player box size.
- `MIN_X` / `MAX_X`, 143 / 784: horizontal display bounds.
- `MIN_Y` / `MAX_Y`, 34 / 516: vertical display bounds.
- `INIT_X` / `INIT_Y`, 143 / 34: position after reset.
- `FLASH_STEPS`, 32: steps spent in DYING.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE/DEAD; load spawn position.
- `spawn_x`, `spawn_y` in 10 each: position loaded on `start`.
- `blocked` in 4: [0] L, [1] R, [2] U, [3] D; 1 = move forbidden.
- `kill` in 1: explosion covers enemy (pulse or level).
- `hit_clr` in 1: clears sticky `player_hit`.
- `b_x`, `b_y` in 10 each: player top-left.
- `v_x`, `v_y` in 10 each: current VGA pixel.
- `enemy_x`, `enemy_y` out 10 each: enemy top-left.
- `dir` out 4: one-hot L=1000, R=0100, U=0010, D=0001, idle=0000.
- `alive` out 1: state is MOVE.
- `player_hit` out 1: sticky player/enemy overlap flag.
- `enemy_on` out 1: pixel inside the visible sprite.
- `spr_row`, `spr_col` out $clog2(SPR_H), $clog2(SPR_W): ROM address.

## Operation
- Wall limits: L = MIN_X, R = MAX_X−SPR_W, U = MIN_Y, D = MAX_Y−SPR_H. A direction is open when its `blocked` bit is 0 and the enemy is not at that wall.
- States:
  - IDLE: on `start`, load spawn position, dir := L (patrol) or 0000 (chase), clear the step counter, go to MOVE.
  - MOVE: on each step tick, move 1 pixel in `dir` if that direction is open.
    - Patrol: if `dir` is not open, rotate clockwise L→U→R→D→L on that tick; the position is unchanged on that tick. If all four directions are blocked, hold position.
    - Chase: on the tick, compute dx = b_x−enemy_x and dy = b_y−enemy_y as signed 11-bit values. Primary axis is the one with larger |d|; ties go to X. Take the primary direction if open, else the secondary direction if its delta is nonzero and it is open, else dir := 0000 and hold.
    - `kill` → DYING.
  - DYING: the position is frozen. `enemy_on` is gated by step-count bit 1, so the sprite flashes every 2 steps. After FLASH_STEPS ticks → DEAD.
  - DEAD: `enemy_on` = 0. `start` respawns as in IDLE.
- Collision uses strict AABB overlap: b_x < ex+SPR_W, ex < b_x+PL_W, b_y < ey+SPR_H, ey < b_y+PL_H. All sums use 11 bits and there is no wrap. Overlap sets `player_hit` only in MOVE. The flag stays set until `hit_clr` or reset; when set and clear occur together, set wins.
- `enemy_on` is the combinational in-box test on (v_x, v_y), gated by state. `spr_col` = v_x−enemy_x and `spr_row` = v_y−enemy_y, truncated.
- Priority in MOVE: `kill` beats movement; a kill and a collision in the same cycle still set `player_hit`.

## Timing
- Reset values: position = INIT, dir = 0000, state IDLE, `alive` = 0, `player_hit` = 0, counter = 0. `enemy_on` is 0 while in IDLE.
- The step counter runs 0..STEP_DIV−1 in MOVE and DYING. The tick is the cycle where count = STEP_DIV−1, and the counter wraps to 0 on that same cycle.
- A position or dir update is registered on the tick and is visible the next cycle.
- State transitions are registered, with 1-cycle latency from `start` or `kill`.
- `player_hit` rises 1 cycle after the overlap condition is true.
- `start` during MOVE or DYING is ignored.
- Reset mid-step aborts immediately and asynchronously, with no partial move.

## Structure
- Shared package `game_pkg`: direction one-hot constants, display bound constants, and state enum (IDLE, MOVE, DYING, DEAD).
- Sub-module `step_timer`, parameter DIV: counter with `en`/`clr` inputs and a `tick` output, reusable by the player and bomb timers.
- Collision and chase arithmetic stay inline.

## Test plan
- Patrol wrap: MODE 0, STEP_DIV = 4, spawn (143, 100), dir L, no blocks. Expect dir→U on the first tick with x unchanged; y decrements every 4 clocks until it reaches 34; then dir→R.
- Blocked turn: MODE 0, spawn (300, 200), blocked = 0001 (L). Expect dir L→U on the first tick and y = 199 on the second tick.
- Chase with axis fallback: MODE 1, enemy (200, 200), player (260, 220), blocked R. Expect the enemy to move D (y+1) each tick until dy = 0, then dir = 0000.
- Collision boundary: enemy (200, 200), player (216, 200). Expect no hit. Move the player to (215, 200): expect `player_hit` = 1 after 1 cycle. Assert `hit_clr` while still overlapping: expect the flag to stay 1.
- Kill cycle: FLASH_STEPS = 4, STEP_DIV = 2, `kill` in MOVE. Expect `enemy_on` to toggle every 2 steps, DEAD after 8 clocks, and a `start` with spawn (400, 300) to restore `alive` at the new position.
- Async reset mid-move: drop `reset_n` on a non-clock edge while in MOVE. Expect all outputs at reset values immediately.
